// File: rtl/multi_port_arbiter.sv
// Arbitrates N cache ports onto one line-wide memory port, one transaction at a time.
// Winner is chosen in IDLE (fixed or round-robin), request is latched, and BUSY holds until mem_resp.
module multi_port_arbiter #(
  parameter int N_PORTS = 2,
  parameter int S_LINE  = 256,
  parameter int RR_MODE = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          port_read,
  input  logic [N_PORTS-1:0]          port_write,
  input  logic [32*N_PORTS-1:0]       port_addr,
  input  logic [S_LINE*N_PORTS-1:0]   port_wdata,
  output logic [S_LINE*N_PORTS-1:0]   port_rdata,
  output logic [N_PORTS-1:0]          port_resp,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [31:0]                 mem_addr,
  output logic [S_LINE-1:0]           mem_wdata,
  input  logic [S_LINE-1:0]           mem_rdata,
  input  logic                        mem_resp,
  output logic [N_PORTS-1:0]          grant,
  output logic                        busy
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       owner_q;
  logic [PW-1:0]       rr_ptr_q;
  logic [PW-1:0]       next_ptr;
  logic [PW-1:0]       winner;
  logic                found;
  logic [31:0]         addr_q;
  logic [S_LINE-1:0]   wdata_q;
  logic                op_read_q;
  logic [N_PORTS-1:0]  req;
  int                  idx;

  assign req = port_read | port_write;

  // Search upward from rr_ptr with wrap; in fixed mode rr_ptr is pinned at 0,
  // so the same search yields the lowest-index requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_PORTS;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  always_comb begin
    next_ptr = (owner_q == PW'(N_PORTS - 1)) ? '0 : owner_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = BUSY;
      BUSY:    if (mem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      owner_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_read_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        owner_q   <= winner;
        addr_q    <= port_addr[32*winner +: 32];
        wdata_q   <= port_wdata[S_LINE*winner +: S_LINE];
        op_read_q <= port_read[winner];
      end
      if (state_q == BUSY && mem_resp) begin
        rr_ptr_q <= (RR_MODE != 0) ? next_ptr : '0;
      end
    end
  end

  // Everything visible is gated by BUSY so IDLE (and post-reset) drives all zeros.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    grant      = '0;
    busy       = 1'b0;
    port_resp  = '0;
    port_rdata = '0;
    if (state_q == BUSY) begin
      busy           = 1'b1;
      grant[owner_q] = 1'b1;
      mem_read       = op_read_q;
      mem_write      = !op_read_q;
      mem_addr       = addr_q;
      mem_wdata      = wdata_q;
      if (mem_resp) begin
        port_resp[owner_q] = 1'b1;
        if (op_read_q) port_rdata[S_LINE*owner_q +: S_LINE] = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_multi_port_arbiter.sv
// Directed bench for multi_port_arbiter: a round-robin instance and a fixed-priority instance,
// both with 4 ports, driven from one initial block with hand-computed expectations.
module tb_multi_port_arbiter;

  localparam int N  = 4;
  localparam int SL = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // round-robin instance
  logic [N-1:0]      a_read, a_write, a_resp, a_grant;
  logic [32*N-1:0]   a_addr;
  logic [SL*N-1:0]   a_wdata, a_rdata;
  logic              a_mem_read, a_mem_write, a_mem_resp, a_busy;
  logic [31:0]       a_mem_addr;
  logic [SL-1:0]     a_mem_wdata, a_mem_rdata;

  // fixed-priority instance
  logic [N-1:0]      b_read, b_write, b_resp, b_grant;
  logic [32*N-1:0]   b_addr;
  logic [SL*N-1:0]   b_wdata, b_rdata;
  logic              b_mem_read, b_mem_write, b_mem_resp, b_busy;
  logic [31:0]       b_mem_addr;
  logic [SL-1:0]     b_mem_wdata, b_mem_rdata;

  logic [SL-1:0]     pat_a5;
  logic [SL-1:0]     pat_d;
  logic [SL-1:0]     pat_r0;

  multi_port_arbiter #(.N_PORTS(N), .S_LINE(SL), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst),
    .port_read(a_read), .port_write(a_write), .port_addr(a_addr), .port_wdata(a_wdata),
    .port_rdata(a_rdata), .port_resp(a_resp),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_resp(a_mem_resp),
    .grant(a_grant), .busy(a_busy)
  );

  multi_port_arbiter #(.N_PORTS(N), .S_LINE(SL), .RR_MODE(0)) dut_fx (
    .clk(clk), .rst(rst),
    .port_read(b_read), .port_write(b_write), .port_addr(b_addr), .port_wdata(b_wdata),
    .port_rdata(b_rdata), .port_resp(b_resp),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp),
    .grant(b_grant), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a(input string tag);
    chk({tag, "_busy"},  256'(a_busy),      256'(0));
    chk({tag, "_grant"}, 256'(a_grant),     256'(0));
    chk({tag, "_mrd"},   256'(a_mem_read),  256'(0));
    chk({tag, "_mwr"},   256'(a_mem_write), 256'(0));
    chk({tag, "_maddr"}, 256'(a_mem_addr),  256'(0));
    chk({tag, "_mwd"},   a_mem_wdata,       256'(0));
    chk({tag, "_resp"},  256'(a_resp),      256'(0));
    chk({tag, "_rdz"},   256'(a_rdata == '0), 256'(1));
  endtask

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_d  = {8{32'hDEAD_BEEF}};
    pat_r0 = {16{16'h1234}};
    a_read = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_mem_rdata = '0; a_mem_resp = 1'b0;
    b_read = '0; b_write = '0; b_addr = '0; b_wdata = '0; b_mem_rdata = '0; b_mem_resp = 1'b0;

    // reset
    step();
    step();
    rst = 1'b0;
    idle_a("rst0");
    chk("rst0_b_busy", 256'(b_busy), 256'(0));

    // single read: port 2 at 0x1040, memory answers in the third BUSY cycle
    a_read = 4'b0100;
    a_addr[32*2 +: 32] = 32'h0000_1040;
    step();
    a_read = '0;
    chk("rd_grant", 256'(a_grant), 256'(4'b0100));
    chk("rd_busy",  256'(a_busy), 256'(1));
    chk("rd_addr",  256'(a_mem_addr), 256'(32'h1040));
    chk("rd_c1",    256'({a_mem_read, a_mem_write}), 256'(2'b10));
    chk("rd_c1_resp", 256'(a_resp), 256'(0));
    step();
    chk("rd_c2",    256'({a_mem_read, a_mem_write}), 256'(2'b10));
    chk("rd_c2_resp", 256'(a_resp), 256'(0));
    step();
    a_mem_resp = 1'b1;
    a_mem_rdata = pat_a5;
    #1;
    chk("rd_c3",    256'({a_mem_read, a_mem_write}), 256'(2'b10));
    chk("rd_resp",  256'(a_resp), 256'(4'b0100));
    chk("rd_data",  a_rdata[SL*2 +: SL], pat_a5);
    chk("rd_other", 256'({a_rdata[SL*3 +: SL], a_rdata[0 +: 2*SL]} == '0), 256'(1));
    step();
    a_mem_resp = 1'b0;
    #1;
    idle_a("rd_end");

    // fairness: all four request continuously from rr_ptr=0, 2-cycle memory
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_read = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr%0d_grant", k), 256'(a_grant), 256'(4'b0001 << (k % 4)));
      step();
      a_mem_resp = 1'b1;
      #1;
      chk($sformatf("rr%0d_resp", k), 256'(a_resp), 256'(4'b0001 << (k % 4)));
      step();
      a_mem_resp = 1'b0;
      #1;
      chk($sformatf("rr%0d_idle", k), 256'(a_busy), 256'(0));
    end
    a_read = '0;

    // port 1 write, then owner changes address/data mid-transaction
    a_write = 4'b0010;
    a_addr[32*1 +: 32] = 32'h0000_2000;
    a_wdata[SL*1 +: SL] = pat_d;
    step();
    chk("wr_grant", 256'(a_grant), 256'(4'b0010));
    chk("wr_op",    256'({a_mem_read, a_mem_write}), 256'(2'b01));
    chk("wr_addr",  256'(a_mem_addr), 256'(32'h2000));
    chk("wr_data",  a_mem_wdata, pat_d);
    a_write = '0;
    a_addr[32*1 +: 32] = 32'h0000_3000;
    a_wdata[SL*1 +: SL] = ~pat_d;
    step();
    chk("wr_addr_hold", 256'(a_mem_addr), 256'(32'h2000));
    chk("wr_data_hold", a_mem_wdata, pat_d);
    a_mem_resp = 1'b1;
    a_mem_rdata = pat_a5;
    #1;
    chk("wr_resp", 256'(a_resp), 256'(4'b0010));
    chk("wr_rdz",  256'(a_rdata == '0), 256'(1));
    step();
    a_mem_resp = 1'b0;
    #1;
    idle_a("wr_end");
    step();
    chk("wr_no_second", 256'(a_resp), 256'(0));

    // read and write together on port 0: read wins
    a_read = 4'b0001;
    a_write = 4'b0001;
    a_addr[0 +: 32] = 32'h0000_0080;
    step();
    a_read = '0;
    a_write = '0;
    chk("rw_op",    256'({a_mem_read, a_mem_write}), 256'(2'b10));
    chk("rw_grant", 256'(a_grant), 256'(4'b0001));
    a_mem_resp = 1'b1;
    a_mem_rdata = pat_r0;
    #1;
    chk("rw_resp", 256'(a_resp), 256'(4'b0001));
    chk("rw_data", a_rdata[0 +: SL], pat_r0);
    step();
    a_mem_resp = 1'b0;
    #1;

    // reset in BUSY cycle 2; rr_ptr (now 1) must go back to 0
    a_read = 4'b0100;
    step();
    a_read = '0;
    chk("rs_grant", 256'(a_grant), 256'(4'b0100));
    step();
    chk("rs_c2_busy", 256'(a_busy), 256'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_a("rs_after");
    a_read = 4'b1001;
    step();
    chk("rs_next_grant", 256'(a_grant), 256'(4'b0001));
    a_read = '0;
    a_mem_resp = 1'b1;
    #1;
    chk("rs_next_resp", 256'(a_resp), 256'(4'b0001));
    step();
    a_mem_resp = 1'b0;
    #1;

    // fixed priority: ports 1 and 3 request continuously, port 1 always wins
    b_read = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fx%0d_grant", k), 256'(b_grant), 256'(4'b0010));
      step();
      b_mem_resp = 1'b1;
      #1;
      chk($sformatf("fx%0d_resp", k), 256'(b_resp), 256'(4'b0010));
      step();
      b_mem_resp = 1'b0;
      #1;
      chk($sformatf("fx%0d_idle", k), 256'(b_busy), 256'(0));
    end
    b_read = '0;

    // stray mem_resp in IDLE is ignored
    step();
    b_mem_resp = 1'b1;
    #1;
    chk("stray_resp", 256'(b_resp), 256'(0));
    step();
    chk("stray_busy", 256'(b_busy), 256'(0));
    chk("stray_resp2", 256'(b_resp), 256'(0));
    b_mem_resp = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_port_arbiter.md
MULTI_PORT_ARBITER -- requirements
Module: multi_port_arbiter

Interface
REQ-001 Parameter N_PORTS, default 2: number of requesting cache ports, legal range 2..8.
REQ-002 Parameter S_LINE, default 256: cache line width in bits.
REQ-003 Parameter RR_MODE, default 1: 1 = round-robin priority, 0 = fixed priority with port 0 highest.
REQ-004 Port list: name, direction, width, meaning.
- clk, in, 1: the single clock; all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- port_read, in, N_PORTS: per-port line read request.
- port_write, in, N_PORTS: per-port line write request.
- port_addr, in, 32*N_PORTS: per-port address; port i occupies bits [32i+31:32i].
- port_wdata, in, S_LINE*N_PORTS: per-port write line, packed the same way.
- port_rdata, out, S_LINE*N_PORTS: per-port read line.
- port_resp, out, N_PORTS: per-port completion pulse.
- mem_read, out, 1: memory read strobe.
- mem_write, out, 1: memory write strobe.
- mem_addr, out, 32: memory address.
- mem_wdata, out, S_LINE: memory write line.
- mem_rdata, in, S_LINE: memory read line.
- mem_resp, in, 1: memory completion.
- grant, out, N_PORTS: one-hot owner of the memory; zero when idle.
- busy, out, 1: a transaction is in flight.

Function
REQ-005 The block SHALL have two states: IDLE and BUSY.
REQ-006 A port SHALL be "requesting" when its port_read or port_write bit is high.
REQ-007 In IDLE, if any port is requesting, the block SHALL select exactly one winner, register it as owner, and move to BUSY on the next edge.
REQ-008 In IDLE with no port requesting, the block SHALL remain in IDLE.
REQ-009 In fixed mode, the winner SHALL be the lowest-index requesting port.
REQ-010 In RR mode, the winner SHALL be the first requesting port at or above rr_ptr, searching upward and wrapping from N_PORTS-1 to 0.
REQ-011 On the IDLE->BUSY edge, the block SHALL latch the winner's address, its write data, and its operation.
REQ-012 The latched operation SHALL be read when port_read is high, including when port_write is also high; otherwise it SHALL be write.
REQ-013 In BUSY, mem_read or mem_write (exactly one, per the latched operation) SHALL be high continuously until mem_resp.
REQ-014 In BUSY, mem_addr and mem_wdata SHALL come from the latched values. Owner input changes during BUSY SHALL have no effect.
REQ-015 Latency: a request sampled in IDLE at edge t SHALL see the memory strobe asserted in the cycle following edge t.
REQ-016 When mem_resp is high in BUSY, in that same cycle:
- port_resp[owner] SHALL be 1.
- For a read, port_rdata[owner] SHALL equal mem_rdata.
- The next state SHALL be IDLE.
REQ-017 On that completion edge, in RR mode, rr_ptr SHALL become (owner+1) mod N_PORTS. In fixed mode, rr_ptr SHALL hold at 0.
REQ-018 There SHALL be at least one IDLE cycle between consecutive grants. Memory strobes SHALL be low in IDLE.
REQ-019 Non-owner ports SHALL always see port_resp=0 and port_rdata=0. All port_rdata slices SHALL be 0 for writes and in IDLE.
REQ-020 grant SHALL equal the one-hot owner in BUSY and 0 in IDLE. busy SHALL be 1 exactly in BUSY.
REQ-021 mem_addr and mem_wdata SHALL be 0 in IDLE.
REQ-022 A mem_resp arriving in IDLE SHALL be ignored.

Reset
REQ-023 On rst high at an edge, regardless of state, the block SHALL:
- enter IDLE;
- set rr_ptr to 0;
- clear owner and the latched address, data and operation to 0.
REQ-024 After reset, every output SHALL be 0. An in-flight transaction SHALL be abandoned with no port_resp.

Verification
REQ-025 The bench SHALL cover at least these scenarios with N_PORTS=4 and RR_MODE=1:
- Single read: port 2 reads 0x0000_1040, memory responds after 3 cycles with 0xA5 pattern -> mem_read high for 3 cycles at 0x1040; port_resp[2] pulses once with matching rdata; grant=0100 while busy.
- All-request fairness: ports 0-3 request continuously, 2-cycle memory -> grants rotate 0,1,2,3,0 with one IDLE cycle between each.
- Owner changes inputs: port 1 write to 0x2000 with data D, then changes addr and data mid-BUSY -> mem_addr stays 0x2000, mem_wdata stays D, port_resp[1] pulses once.
- Read and write together: port 0 asserts both -> mem_read=1 and mem_write=0.
- Reset mid-transaction: rst in BUSY cycle 2 -> next cycle all outputs 0 and no port_resp; next grant starts from port 0.
REQ-026 The bench SHALL also cover RR_MODE=0: ports 1 and 3 request continuously -> port 1 always wins and port 3 is starved; a stray mem_resp in IDLE produces no port_resp.
